// File: rtl/q_learn_pkg.sv
// Shared constants and FSM encoding for the Q-learning action-select, pipeline and writeback stages.
package q_learn_pkg;

  localparam int STATE_W = 6;
  localparam int ACT_W   = 2;
  localparam int Q_W     = 32;
  localparam int EPS_W   = 8;
  localparam int NUM_ACT = 2 ** ACT_W;

  // Feedback taps 16,14,13,11 (1-based from the LSB) of the 16-bit exploration LFSR.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sel_state_e;

endpackage

// File: rtl/eps_greedy_action_select_if.sv
// Request, Q-table read and action-result channels of the epsilon-greedy selector.
interface eps_greedy_action_select_if #(
  parameter int STATE_W = q_learn_pkg::STATE_W,
  parameter int ACT_W   = q_learn_pkg::ACT_W,
  parameter int Q_W     = q_learn_pkg::Q_W,
  parameter int EPS_W   = q_learn_pkg::EPS_W
);

  logic                     st_valid;
  logic                     st_ready;
  logic [STATE_W-1:0]       st_idx;
  logic [EPS_W-1:0]         epsilon;
  logic [STATE_W+ACT_W-1:0] q_raddr;
  logic                     q_ren;
  logic [Q_W-1:0]           q_rdata;
  logic                     act_valid;
  logic                     act_ready;
  logic [ACT_W-1:0]         act_out;
  logic [Q_W-1:0]           max_q;
  logic                     explored;

  // The selector owns the Q-table read sequence and the result channel.
  modport master (
    input  st_valid, st_idx, epsilon, q_rdata, act_ready,
    output st_ready, q_raddr, q_ren, act_valid, act_out, max_q, explored
  );

  modport slave (
    output st_valid, st_idx, epsilon, q_rdata, act_ready,
    input  st_ready, q_raddr, q_ren, act_valid, act_out, max_q, explored
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed falls back to the default so it never locks up.
module lfsr16
  import q_learn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else begin
      out <= {out[14:0], ^(out & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/eps_greedy_action_select.sv
// Reads the Q-values of one state, forms the signed argmax and applies epsilon-greedy exploration.
module eps_greedy_action_select
  import q_learn_pkg::*;
#(
  parameter int          STATE_W   = q_learn_pkg::STATE_W,
  parameter int          ACT_W     = q_learn_pkg::ACT_W,
  parameter int          Q_W       = q_learn_pkg::Q_W,
  parameter int          EPS_W     = q_learn_pkg::EPS_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  eps_greedy_action_select_if.master  bus
);

  localparam int NUM_ACT = 2 ** ACT_W;

  logic [15:0]            lfsr;
  sel_state_e             state;
  logic [STATE_W-1:0]     st_q;
  logic [EPS_W-1:0]       eps_q;
  logic [15:0]            rnd;
  logic [ACT_W-1:0]       k;
  logic signed [Q_W-1:0]  best;
  logic [ACT_W-1:0]       best_idx;

  logic [ACT_W-1:0]       data_idx;
  logic                   take;
  logic signed [Q_W-1:0]  best_nxt;
  logic [ACT_W-1:0]       idx_nxt;
  logic                   explore;
  logic                   unused_rnd;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr)
  );

  // Only the low epsilon bits and the top action bits of the snapshot steer the choice.
  assign unused_rnd = ^rnd[15-ACT_W:EPS_W];

  // Read data trails its address by one cycle, so FETCH folds index k-1 and DRAIN folds the last one.
  // NOTE: every signal gets a value on every path, so no latch can be inferred.
  always_comb begin
    data_idx = (state == ST_DRAIN) ? k : k - 1'b1;
    take     = (data_idx == '0) || ($signed(bus.q_rdata) > best);
    best_nxt = take ? $signed(bus.q_rdata) : best;
    idx_nxt  = take ? data_idx : best_idx;
    explore  = rnd[EPS_W-1:0] < eps_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      st_q          <= '0;
      eps_q         <= '0;
      rnd           <= '0;
      k             <= '0;
      best          <= '0;
      best_idx      <= '0;
      bus.st_ready  <= 1'b1;
      bus.q_ren     <= 1'b0;
      bus.q_raddr   <= '0;
      bus.act_valid <= 1'b0;
      bus.act_out   <= '0;
      bus.max_q     <= '0;
      bus.explored  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.st_valid) begin
            st_q         <= bus.st_idx;
            eps_q        <= bus.epsilon;
            rnd          <= lfsr;
            k            <= '0;
            bus.st_ready <= 1'b0;
            bus.q_ren    <= 1'b1;
            bus.q_raddr  <= {bus.st_idx, {ACT_W{1'b0}}};
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (k != '0) begin
            best     <= best_nxt;
            best_idx <= idx_nxt;
          end
          if (k == ACT_W'(NUM_ACT - 1)) begin
            bus.q_ren <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            k           <= k + 1'b1;
            bus.q_raddr <= {st_q, k + 1'b1};
          end
        end
        ST_DRAIN: begin
          // max_q always reports the greedy maximum, even when the action was explored.
          bus.max_q     <= best_nxt;
          bus.act_out   <= explore ? rnd[15 -: ACT_W] : idx_nxt;
          bus.explored  <= explore;
          bus.act_valid <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.act_ready) begin
            bus.act_valid <= 1'b0;
            bus.st_ready  <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eps_greedy_action_select.sv
// Randomized self-checking bench for eps_greedy_action_select against a behavioural argmax/epsilon model.
module tb_eps_greedy_action_select;
  import q_learn_pkg::*;

  typedef logic signed [Q_W-1:0] qvec_t [NUM_ACT];
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eps_greedy_action_select_if bus ();
  eps_greedy_action_select #(.LFSR_SEED(SEED)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [Q_W-1:0] qmem [256];
  logic [15:0]    m_lfsr;
  logic           ren_trace  [32];
  logic [7:0]     addr_trace [32];

  // Reference LFSR: shift left, new bit = XOR of taps 16,14,13,11 (1-based).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  // Synchronous Q-table: data for an accepted read is visible during the following cycle.
  always @(posedge clk) begin : q_table
    logic       r;
    logic [7:0] a;
    r = bus.q_ren;
    a = bus.q_raddr;
    #1;
    bus.q_rdata = r ? qmem[a] : 32'hDEAD_BEEF;
  end

  // Greedy = first index holding the maximum; explore when the low byte of rnd is below epsilon.
  function automatic void model(input qvec_t q, input logic [15:0] rnd, input logic [7:0] eps,
                                output logic [1:0] act, output logic [31:0] mq, output logic expl);
    logic signed [31:0] mx;
    int gi;
    mx = q[0];
    foreach (q[i]) if (q[i] > mx) mx = q[i];
    gi = -1;
    foreach (q[i]) if (gi < 0 && q[i] == mx) gi = i;
    expl = int'(rnd[7:0]) < int'(eps);
    act  = expl ? rnd[15:14] : 2'(gi);
    mq   = mx;
  endfunction

  task automatic load_q(input logic [5:0] st, input qvec_t q);
    for (int i = 0; i < NUM_ACT; i++) qmem[{st, 2'(i)}] = q[i];
  endtask

  // Entered and left just after a falling edge; lat counts cycles from accept to act_valid.
  task automatic issue(input logic [5:0] st, input logic [7:0] eps, output logic [15:0] rnd,
                       output int lat, output int waits, output bit to);
    to = 0; waits = 0; lat = 0; rnd = '0;
    bus.st_valid = 1'b1; bus.st_idx = st; bus.epsilon = eps;
    while (!bus.st_ready && waits < 20) begin @(negedge clk); waits++; end
    if (!bus.st_ready) begin to = 1; bus.st_valid = 1'b0; return; end
    rnd = m_lfsr;
    @(negedge clk);
    bus.st_valid = 1'b0; bus.st_idx = 6'($urandom); bus.epsilon = ~eps;
    lat = 1; ren_trace[1] = bus.q_ren; addr_trace[1] = bus.q_raddr;
    while (!bus.act_valid && lat < 20) begin
      @(negedge clk); lat++;
      ren_trace[lat] = bus.q_ren; addr_trace[lat] = bus.q_raddr;
    end
    if (!bus.act_valid) to = 1;
  endtask

  task automatic release_out();
    bus.act_ready = 1'b1;
    @(negedge clk);
    bus.act_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", bus.st_ready); end
    checks++; if ({bus.q_ren, bus.act_valid, bus.explored} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.q_ren, bus.act_valid, bus.explored}); end
    checks++; if ({bus.q_raddr, bus.act_out, bus.max_q} !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.q_raddr, bus.act_out, bus.max_q}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.st_ready, bus.act_valid} !== 2'b10) begin errors++; $display("FAIL post_reset_idle: got %b want 10", {bus.st_ready, bus.act_valid}); end
  endtask

  task automatic test_greedy();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; logic [7:0] ea;
    q = '{32'sd10, -32'sd3, 32'sd42, 32'sd7};
    load_q(6'd5, q);
    issue(6'd5, 8'd0, rnd, lat, waits, to);
    checks++;
    if (to) begin errors++; $display("FAIL greedy_timeout: no act_valid within 20 cycles"); return; end
    if (lat != 6) begin errors++; $display("FAIL greedy_latency: got %0d want 6", lat); end
    for (int c = 1; c <= 4; c++) begin
      ea = 8'h13 + 8'(c);
      checks++;
      if (ren_trace[c] !== 1'b1 || addr_trace[c] !== ea) begin
        errors++; $display("FAIL greedy_read_c%0d: got ren=%b addr=%h want ren=1 addr=%h", c, ren_trace[c], addr_trace[c], ea);
      end
    end
    checks++; if (ren_trace[5] !== 1'b0 || addr_trace[5] !== 8'h17) begin errors++; $display("FAIL greedy_read_idle: got ren=%b addr=%h want ren=0 addr=17", ren_trace[5], addr_trace[5]); end
    checks++; if (bus.act_out !== 2'd2) begin errors++; $display("FAIL greedy_act: got %0d want 2", bus.act_out); end
    checks++; if (bus.max_q !== 32'd42) begin errors++; $display("FAIL greedy_max_q: got %0d want 42", $signed(bus.max_q)); end
    checks++; if (bus.explored !== 1'b0) begin errors++; $display("FAIL greedy_explored: got %b want 0", bus.explored); end
    release_out();
  endtask

  task automatic test_ties();
    qvec_t cases [2]; logic [31:0] want_mq [2]; logic [15:0] rnd; int lat, waits; bit to;
    cases[0] = '{-32'sd5, -32'sd5, -32'sd9, -32'sd5};
    cases[1] = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
    want_mq[0] = 32'hFFFF_FFFB;
    want_mq[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      load_q(6'(20 + i), cases[i]);
      issue(6'(20 + i), 8'd0, rnd, lat, waits, to);
      checks++;
      if (to) begin errors++; $display("FAIL ties_%0d_timeout: no act_valid", i); continue; end
      if ({bus.act_out, bus.max_q, bus.explored} !== {2'd0, want_mq[i], 1'b0}) begin
        errors++; $display("FAIL ties_%0d: got act=%0d max_q=%h expl=%b want act=0 max_q=%h expl=0", i, bus.act_out, bus.max_q, bus.explored, want_mq[i]);
      end
      release_out();
    end
  endtask

  task automatic check_result(input string name, input qvec_t q, input logic [15:0] rnd, input logic [7:0] eps);
    logic [1:0] ea; logic [31:0] em; logic ee;
    model(q, rnd, eps, ea, em, ee);
    checks++;
    if ({bus.act_out, bus.max_q, bus.explored} !== {ea, em, ee}) begin
      errors++; $display("FAIL %s: got act=%0d max_q=%h expl=%b want act=%0d max_q=%h expl=%b (rnd=%h eps=%0d)", name, bus.act_out, bus.max_q, bus.explored, ea, em, ee, rnd, eps);
    end
  endtask

  task automatic test_explore();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; logic [5:0] st;
    for (int n = 0; n < 8; n++) begin
      st = 6'($urandom);
      foreach (q[i]) q[i] = $urandom;
      load_q(st, q);
      issue(st, 8'd255, rnd, lat, waits, to);
      if (to) begin checks++; errors++; $display("FAIL explore_timeout: request %0d", n); continue; end
      check_result("explore", q, rnd, 8'd255);
      release_out();
    end
  endtask

  task automatic test_backpressure();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; logic [1:0] ea; logic [31:0] em; logic ee;
    foreach (q[i]) q[i] = $urandom;
    load_q(6'd33, q);
    issue(6'd33, 8'd128, rnd, lat, waits, to);
    if (to) begin checks++; errors++; $display("FAIL backpressure_timeout: no act_valid"); return; end
    model(q, rnd, 8'd128, ea, em, ee);
    for (int c = 0; c < 5; c++) begin
      bus.st_valid = 1'b1; bus.epsilon = 8'($urandom);
      checks++;
      if ({bus.act_valid, bus.st_ready, bus.act_out, bus.max_q, bus.explored} !== {2'b10, ea, em, ee}) begin
        errors++; $display("FAIL backpressure_hold_c%0d: got v=%b rdy=%b act=%0d max_q=%h expl=%b want v=1 rdy=0 act=%0d max_q=%h expl=%b", c, bus.act_valid, bus.st_ready, bus.act_out, bus.max_q, bus.explored, ea, em, ee);
      end
      @(negedge clk);
    end
    bus.st_valid = 1'b0;
    release_out();
    checks++;
    if ({bus.st_ready, bus.act_valid} !== 2'b10) begin errors++; $display("FAIL backpressure_release: got rdy=%b v=%b want rdy=1 v=0", bus.st_ready, bus.act_valid); end
  endtask

  task automatic test_back_to_back();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; logic [7:0] eps;
    for (int n = 0; n < 6; n++) begin
      foreach (q[i]) q[i] = $urandom;
      eps = 8'($urandom);
      load_q(6'(40 + n), q);
      issue(6'(40 + n), eps, rnd, lat, waits, to);
      checks++;
      if (to) begin errors++; $display("FAIL b2b_timeout: request %0d", n); continue; end
      if (waits != 0 || lat != 6) begin errors++; $display("FAIL b2b_timing_%0d: got waits=%0d lat=%0d want waits=0 lat=6", n, waits, lat); end
      check_result("b2b", q, rnd, eps);
      release_out();
    end
  endtask

  task automatic test_random();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; logic [7:0] eps; logic [5:0] st;
    for (int n = 0; n < 40; n++) begin
      st = 6'($urandom); eps = 8'($urandom);
      foreach (q[i]) begin
        if ($urandom_range(0, 1) == 0) q[i] = $urandom;
        else begin q[i] = $urandom_range(0, 6); q[i] = q[i] - 3; end
      end
      load_q(st, q);
      issue(st, eps, rnd, lat, waits, to);
      if (to) begin checks++; errors++; $display("FAIL random_timeout: request %0d", n); continue; end
      check_result("random", q, rnd, eps);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end
  endtask

  task automatic test_reset_mid_fetch();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to;
    q = '{32'sd1, 32'sd50, 32'sd3, 32'sd4};
    load_q(6'd12, q);
    bus.st_valid = 1'b1; bus.st_idx = 6'd12; bus.epsilon = 8'd0;
    @(negedge clk);
    bus.st_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.q_ren, bus.act_valid, bus.st_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_mid_fetch: got ren=%b v=%b rdy=%b want ren=0 v=0 rdy=1", bus.q_ren, bus.act_valid, bus.st_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Right after release the snapshot must be the seed itself: low byte E1 explores, action = 2'b10.
    issue(6'd12, 8'd255, rnd, lat, waits, to);
    checks++;
    if (to) begin errors++; $display("FAIL reset_resume_timeout: no act_valid"); return; end
    if ({bus.act_out, bus.max_q, bus.explored} !== {2'd2, 32'd50, 1'b1}) begin
      errors++; $display("FAIL reset_resume: got act=%0d max_q=%0d expl=%b want act=2 max_q=50 expl=1", bus.act_out, $signed(bus.max_q), bus.explored);
    end
    release_out();
  endtask

  task automatic test_statistical();
    qvec_t q; logic [15:0] rnd; int lat, waits; bit to; int ex_cnt; int act_cnt [4];
    q = '{32'sd100, 32'sd200, 32'sd300, 32'sd400};
    load_q(6'd9, q);
    ex_cnt = 0;
    foreach (act_cnt[i]) act_cnt[i] = 0;
    for (int n = 0; n < 4096; n++) begin
      issue(6'd9, 8'd64, rnd, lat, waits, to);
      if (to) begin checks++; errors++; $display("FAIL stats_timeout: request %0d", n); break; end
      check_result("stats", q, rnd, 8'd64);
      if (bus.explored === 1'b1) begin ex_cnt++; act_cnt[bus.act_out]++; end
      release_out();
    end
    checks++;
    if (ex_cnt < 902 || ex_cnt > 1146) begin errors++; $display("FAIL stats_rate: got %0d explores want 902..1146 of 4096", ex_cnt); end
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (act_cnt[a] * 16 < ex_cnt * 3 || act_cnt[a] * 16 > ex_cnt * 5) begin
        errors++; $display("FAIL stats_uniform_a%0d: got %0d want about %0d", a, act_cnt[a], ex_cnt / 4);
      end
    end
  endtask

  initial begin
    bus.st_valid = 1'b0; bus.st_idx = '0; bus.epsilon = '0; bus.act_ready = 1'b0;
    foreach (qmem[i]) qmem[i] = '0;
    #2 rst = 1'b0;
    test_reset();
    test_greedy();
    test_ties();
    test_explore();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_fetch();
    test_statistical();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
